udp_tx_framer: RTL

Transmit-side framer. It builds complete Ethernet II / IPv4 / UDP frames, including preamble, SFD, computed IPv4 header checksum, zero padding and FCS, from a payload length and a first-word-fall-through (FWFT) payload byte source. It sits between the application payload FIFO and the byte-to-nibble PHY serializer, and mirrors the receive parser's frame layout.

---
 rtl/eth_types_pkg.sv | 26 ++
 rtl/udp_tx_framer_if.sv | 16 +
 rtl/crc32_d8.sv | 14 +
 rtl/udp_tx_framer.sv | 85 ++++++++
 4 files changed

// File: rtl/eth_types_pkg.sv
// eth_types_pkg: shared Ethernet/IPv4/UDP framing types, constants, CRC-32 byte step and IPv4 header checksum
package eth_types_pkg;
  typedef enum logic [3:0] {
    TX_IDLE, TX_PREAMBLE, TX_ETH_HEADER, TX_IP_HEADER, TX_UDP_HEADER,
    TX_PAYLOAD, TX_PAD, TX_FCS, TX_IFG
  } eth_tx_states;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;
  localparam int MIN_FRAME_BYTES = 60;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB8_8320 : r >> 1;
    return r;
  endfunction
  function automatic logic [15:0] ip_cksum(input logic [15:0] tl, input logic [15:0] id,
                                           input logic [31:0] sip, input logic [31:0] dip);
    logic [19:0] s;
    s = 20'h4500 + 20'(tl) + 20'(id) + 20'h4000 + 20'({8'h40, IP_PROTO_UDP})
      + 20'(sip[31:16]) + 20'(sip[15:0]) + 20'(dip[31:16]) + 20'(dip[15:0]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    return ~s[15:0];
  endfunction
endpackage

// File: rtl/udp_tx_framer_if.sv
// udp_tx_framer_if: framer request, FWFT payload source and tx byte stream; master = framer, slave = its environment
interface udp_tx_framer_if;
  logic start;
  logic [10:0] payload_len;
  logic busy;
  logic [7:0] payload_data;
  logic payload_rd;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic done;
  modport master(input start, payload_len, payload_data, tx_ready,
                 output busy, payload_rd, tx_data, tx_valid, done);
  modport slave(output start, payload_len, payload_data, tx_ready,
                input busy, payload_rd, tx_data, tx_valid, done);
endinterface

// File: rtl/crc32_d8.sv
// crc32_d8: byte-wide reflected CRC-32 register (clk, rst_n, init, en, data in; crc out)
module crc32_d8 import eth_types_pkg::*; (
  input logic clk,
  input logic rst_n,
  input logic init,
  input logic en,
  input logic [7:0] data,
  output logic [31:0] crc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc <= CRC32_INIT;
    else if (init) crc <= CRC32_INIT;
    else if (en) crc <= crc32_byte(crc, data);
endmodule

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: Ethernet/IPv4/UDP frame builder (clk, rst_n; bus: start/payload_len/payload_data/tx_ready in, busy/payload_rd/tx_data/tx_valid/done out)
module udp_tx_framer import eth_types_pkg::*; #(
  parameter logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DEST_MAC = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP = 32'hC0A8_010A,
  parameter logic [31:0] DEST_IP = 32'hC0A8_0101,
  parameter logic [15:0] SRC_PORT = 16'd1234,
  parameter logic [15:0] DEST_PORT = 16'd1234,
  parameter int MAX_PAYLOAD = 1472,
  parameter int IFG_BYTES = 12
) (
  input logic clk,
  input logic rst_n,
  udp_tx_framer_if.master bus
);
  localparam logic [10:0] PAD_MAX = 11'(MIN_FRAME_BYTES - 42);
  eth_tx_states state, nxt;
  logic [10:0] cnt, len, n;
  logic [15:0] ident, cksum, tot_len, udp_len;
  logic [31:0] crc, fcs_sh;
  logic [111:0] eth_sh;
  logic [159:0] ip_sh;
  logic [63:0] udp_sh;
  logic [7:0] tx_d;
  logic last, step, crc_en;
  assign tot_len = {5'd0, len} + 16'd28;
  assign udp_len = {5'd0, len} + 16'd8;
  assign eth_sh = {DEST_MAC, SRC_MAC, ETHERTYPE_IPV4} << (8 * cnt);
  assign ip_sh = {8'h45, 8'h00, tot_len, ident, 16'h4000, 8'h40, IP_PROTO_UDP, cksum, SRC_IP, DEST_IP} << (8 * cnt);
  assign udp_sh = {SRC_PORT, DEST_PORT, udp_len, 16'h0000} << (8 * cnt);
  assign fcs_sh = ~crc >> (8 * cnt);
  assign n = state == TX_PREAMBLE ? 11'd8 : state == TX_ETH_HEADER ? 11'd14 :
             state == TX_IP_HEADER ? 11'd20 : state == TX_UDP_HEADER ? 11'd8 :
             state == TX_PAYLOAD ? len : state == TX_PAD ? PAD_MAX - len :
             state == TX_FCS ? 11'd4 : 11'(IFG_BYTES);
  assign last = cnt == n - 11'd1;
  // IFG cycles count only when tx_ready is high, so every active state advances on tx_ready
  assign step = state != TX_IDLE && bus.tx_ready;
  assign crc_en = step && state inside {TX_ETH_HEADER, TX_IP_HEADER, TX_UDP_HEADER, TX_PAYLOAD, TX_PAD};
  always_comb begin
    tx_d = state == TX_PREAMBLE ? (cnt == 11'd7 ? 8'hD5 : 8'h55) :
           state == TX_ETH_HEADER ? eth_sh[111:104] :
           state == TX_IP_HEADER ? ip_sh[159:152] :
           state == TX_UDP_HEADER ? udp_sh[63:56] :
           state == TX_PAYLOAD ? bus.payload_data :
           state == TX_FCS ? fcs_sh[7:0] : 8'h00;
    case (state)
      TX_PREAMBLE: nxt = TX_ETH_HEADER;
      TX_ETH_HEADER: nxt = TX_IP_HEADER;
      TX_IP_HEADER: nxt = TX_UDP_HEADER;
      TX_UDP_HEADER: nxt = len != 11'd0 ? TX_PAYLOAD : TX_PAD;
      TX_PAYLOAD: nxt = len < PAD_MAX ? TX_PAD : TX_FCS;
      TX_PAD: nxt = TX_FCS;
      TX_FCS: nxt = TX_IFG;
      default: nxt = TX_IDLE;
    endcase
  end
  assign bus.tx_data = tx_d;
  assign bus.tx_valid = state != TX_IDLE && state != TX_IFG;
  assign bus.busy = state != TX_IDLE;
  assign bus.payload_rd = state == TX_PAYLOAD && bus.tx_ready;
  assign bus.done = state == TX_IFG && step && last;
  crc32_d8 u_crc (.clk(clk), .rst_n(rst_n), .init(state == TX_IDLE), .en(crc_en), .data(tx_d), .crc(crc));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= TX_IDLE;
      cnt <= '0;
      len <= '0;
      ident <= '0;
      cksum <= '0;
    end else begin
      if (state == TX_IDLE) begin
        cnt <= '0;
        if (bus.start && bus.payload_len <= 11'(MAX_PAYLOAD)) begin
          len <= bus.payload_len;
          state <= TX_PREAMBLE;
        end
      end else if (step) begin
        cnt <= last ? '0 : cnt + 11'd1;
        if (last) state <= nxt;
      end
      if (state == TX_PREAMBLE) cksum <= ip_cksum(tot_len, ident, SRC_IP, DEST_IP);
      if (bus.done) ident <= ident + 16'd1;
    end
endmodule
